// File: rtl/mul_share_ctrl_pkg.sv
// rtl/mul_share_ctrl_pkg.sv - shared types and defaults for the shared-multiplier controller
package mul_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CALC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int DEF_N     = 8;
    localparam int DEF_NREQ  = 2;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/multiplier.sv
// rtl/multiplier.sv - combinational N x N unsigned multiplier with exact 2N-bit product
module multiplier #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    assign p = (2*N)'(a) * (2*N)'(b);

endmodule

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin controller time-sharing one multiplier among requesters
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int NREQ   = DEF_NREQ,
    parameter int CNT_W  = DEF_CNT_W,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [2*N-1:0]    resp_p,
    output logic              resp_ovf,
    output logic [IDW-1:0]    resp_id,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic [2*N-1:0]   product;

    logic             pick_found;
    logic [IDW-1:0]   pick_id;
    logic [NREQ-1:0]  upper_valid;

    // Prefer the lowest valid index at or above rr_ptr; otherwise wrap to the lowest valid overall.
    always_comb begin
        upper_valid = '0;
        pick_found  = 1'b0;
        pick_id     = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper_valid[i] = req_valid[i] && (i >= int'(rr_ptr));
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (upper_valid[i]) begin
                pick_id = IDW'(i);
            end
        end
    end

    multiplier #(.N(N)) u_multiplier (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            req_ready  <= '0;
            resp_valid <= 1'b0;
            resp_p     <= '0;
            resp_ovf   <= 1'b0;
            resp_id    <= '0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_id;
                        rr_ptr    <= (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + 1'b1;
                        req_ready <= NREQ'(1) << pick_id;
                        busy      <= 1'b1;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    req_ready <= '0;
                    // A requester that withdrew during its grant cycle gets no response.
                    if (req_valid[grant_id]) begin
                        op_a  <= req_a[grant_id*N +: N];
                        op_b  <= req_b[grant_id*N +: N];
                        state <= ST_CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    resp_p     <= product;
                    resp_ovf   <= |product[2*N-1:N];
                    resp_id    <= grant_id;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        op_count   <= op_count + 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - directed self-checking bench for mul_share_ctrl
module tb_mul_share_ctrl;

    localparam int N     = 8;
    localparam int NREQ  = 2;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [2*N-1:0]    resp_p;
    logic              resp_ovf;
    logic [0:0]        resp_id;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    int checks   = 0;
    int failures = 0;

    mul_share_ctrl #(.N(N), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_p     (resp_p),
        .resp_ovf   (resp_ovf),
        .resp_id    (resp_id),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on requester idx, wait through GRANT/CALC, check RESP, then handshake.
    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input logic exp_ovf,
                          input logic [15:0] exp_cnt);
        req_a[idx*N +: N] = a;
        req_b[idx*N +: N] = b;
        req_valid = NREQ'(1) << idx;
        tick();
        check("grant_ready", 32'(req_ready), 32'(NREQ'(1) << idx));
        check("grant_busy", 32'(busy), 32'd1);
        tick();
        req_valid = '0;
        check("calc_ready_low", 32'(req_ready), 32'd0);
        check("calc_no_resp", 32'(resp_valid), 32'd0);
        tick();
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_p", 32'(resp_p), 32'(exp_p));
        check("resp_ovf", 32'(resp_ovf), 32'(exp_ovf));
        check("resp_id", 32'(resp_id), 32'(idx));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("hs_valid_low", 32'(resp_valid), 32'd0);
        check("hs_count", 32'(op_count), 32'(exp_cnt));
        check("hs_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_p", 32'(resp_p), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        run_op(0, 8'd13, 8'd11, 16'd143, 1'b0, 16'd1);
        run_op(1, 8'd255, 8'd255, 16'hFE01, 1'b1, 16'd2);
        run_op(1, 8'd0, 8'd200, 16'd0, 1'b0, 16'd3);

        // Both valid, consumer always ready: grants alternate, one response every 4 cycles.
        req_a      = {8'd20, 8'd3};
        req_b      = {8'd30, 8'd5};
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            tick();
            check("rr_valid", 32'(resp_valid), 32'd1);
            check("rr_id", 32'(resp_id), 32'(k % 2));
            check("rr_p", 32'(resp_p), (k % 2 == 0) ? 32'd15 : 32'd600);
            check("rr_ovf", 32'(resp_ovf), (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            if (k == 3) req_valid = '0;
            check("rr_idle_valid", 32'(resp_valid), 32'd0);
        end
        resp_ready = 1'b0;
        check("rr_count", 32'(op_count), 32'd7);

        // Back-pressure in RESP: outputs hold, no grant while busy.
        req_a[7:0] = 8'd100;
        req_b[7:0] = 8'd3;
        req_valid  = 2'b01;
        tick();
        check("bp_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid  = 2'b10;
        req_a[7:0] = 8'd7;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_p", 32'(resp_p), 32'd300);
            check("bp_ovf", 32'(resp_ovf), 32'd1);
            check("bp_id", 32'(resp_id), 32'd0);
            check("bp_no_grant", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_hs_valid", 32'(resp_valid), 32'd0);
        check("bp_hs_count", 32'(op_count), 32'd8);
        tick();
        check("bp_next_grant", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        tick();
        check("bp_next_p", 32'(resp_p), 32'd600);
        check("bp_next_id", 32'(resp_id), 32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_next_count", 32'(op_count), 32'd9);

        // Reset during CALC discards the op.
        req_a[7:0] = 8'd13;
        req_b[7:0] = 8'd11;
        req_valid  = 2'b01;
        tick();
        tick();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_count", 32'(op_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_p", 32'(resp_p), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", 32'(resp_valid), 32'd0);

        // Requester 1 withdraws during its grant; stray resp_ready is ignored.
        req_valid = 2'b10;
        tick();
        check("abort_grant", 32'(req_ready), 32'd2);
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        tick();
        check("abort_no_resp", 32'(resp_valid), 32'd0);
        check("abort_count", 32'(op_count), 32'd0);
        resp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
